// File: rtl/buffer_pkg.sv
// rtl/buffer_pkg.sv - shared defaults and types for the UART-to-game byte buffer
package buffer_pkg;

    localparam int WIDTH_DEF = 8;
    localparam int DEPTH_DEF = 4;

    typedef logic [WIDTH_DEF-1:0] byte_t;

    // Count needs one bit more than a pointer so that full and empty differ.
    function automatic int count_bits(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/byte_fifo.sv
// rtl/byte_fifo.sv - circular byte FIFO with pointers, count and full/empty flags
module byte_fifo
    import buffer_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           push,
    input  logic                           pop,
    input  logic [WIDTH-1:0]               wdata,
    output logic [WIDTH-1:0]               rdata,
    output logic                           full,
    output logic                           empty,
    output logic [count_bits(DEPTH)-1:0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = count_bits(DEPTH);

    localparam logic [PW-1:0] PTR_ONE   = PW'(1);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);
    localparam logic [CW-1:0] CNT_DEPTH = CW'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;

    // Caller guarantees push only when not full (or popping) and pop only when not empty.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;

        if (push) begin
            mem_d[wr_ptr_q] = wdata;
            wr_ptr_d        = wr_ptr_q + PTR_ONE;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end

        unique case ({push, pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage contents are don't-care after reset, so no reset branch here.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign rdata = mem_q[rd_ptr_q];
    assign full  = (count_q == CNT_DEPTH);
    assign empty = (count_q == '0);
    assign count = count_q;

endmodule

// File: rtl/buffer.sv
// rtl/buffer.sv - queues receiver bytes and hands the oldest to the game on request
module buffer
    import buffer_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic             clk,
    input  logic             nRst,
    input  logic             ready,
    input  logic [WIDTH-1:0] Rx_byte,
    input  logic             game_rdy,
    output logic [WIDTH-1:0] guess
);

    localparam int CW = count_bits(DEPTH);

    logic             ready_q, ready_d;
    logic [WIDTH-1:0] guess_q, guess_d;

    logic             push_req;
    logic             push_ok;
    logic             pop_ok;
    logic [WIDTH-1:0] head;
    logic             fifo_full;
    logic             fifo_empty;
    logic [CW-1:0]    fifo_count;

    // A long ready level yields one push; a pop frees a slot so a push at full is kept.
    always_comb begin
        ready_d  = ready;
        push_req = ready & ~ready_q;
        pop_ok   = game_rdy & ~fifo_empty;
        push_ok  = push_req & (~fifo_full | pop_ok);
        guess_d  = pop_ok ? head : guess_q;
    end

    always_ff @(posedge clk) begin
        if (nRst) begin
            ready_q <= 1'b0;
            guess_q <= '0;
        end else begin
            ready_q <= ready_d;
            guess_q <= guess_d;
        end
    end

    byte_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (nRst),
        .push  (push_ok),
        .pop   (pop_ok),
        .wdata (Rx_byte),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign guess = guess_q;

endmodule

// File: tb/tb_buffer.sv
// tb/tb_buffer.sv - table-driven self-checking bench for buffer
module tb_buffer;
    import buffer_pkg::*;

    logic  clk = 1'b0;
    logic  nRst;
    logic  ready;
    byte_t Rx_byte;
    logic  game_rdy;
    byte_t guess;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic  rst;
        logic  rdy;
        byte_t rx;
        logic  grdy;
        byte_t exp_guess;
        int    exp_count;
    } vec_t;

    vec_t vecs[$];

    buffer dut (
        .clk      (clk),
        .nRst     (nRst),
        .ready    (ready),
        .Rx_byte  (Rx_byte),
        .game_rdy (game_rdy),
        .guess    (guess)
    );

    always #5 clk = ~clk;

    task automatic add(input logic r, input logic rd, input int rx, input logic g,
                       input int eg, input int ec);
        vec_t v;
        v.rst = r; v.rdy = rd; v.rx = byte_t'(rx); v.grdy = g;
        v.exp_guess = byte_t'(eg); v.exp_count = ec;
        vecs.push_back(v);
    endtask

    task automatic drive(input logic r, input logic rd, input byte_t rx, input logic g);
        nRst = r; ready = rd; Rx_byte = rx; game_rdy = g;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    initial begin
        drive(1'b1, 1'b0, 8'd5, 1'b0);

        // reset and idle
        add(1,0,5,0, 0,0);   add(1,0,5,0, 0,0);   add(0,0,5,0, 0,0);
        // single push with ready held, then pop and hold on empty
        add(0,1,5,0, 0,1);   add(0,1,5,0, 0,1);
        add(0,0,5,1, 5,0);   add(0,0,5,1, 5,0);   add(0,0,5,0, 5,0);
        // fill 1..4, fifth byte dropped at full
        add(0,1,1,0, 5,1);   add(0,0,1,0, 5,1);   add(0,1,2,0, 5,2);   add(0,0,2,0, 5,2);
        add(0,1,3,0, 5,3);   add(0,0,3,0, 5,3);   add(0,1,4,0, 5,4);   add(0,0,4,0, 5,4);
        add(0,1,9,0, 5,4);
        // drain one per cycle, then hold
        add(0,0,9,1, 1,3);   add(0,0,9,1, 2,2);   add(0,0,9,1, 3,1);   add(0,0,9,1, 4,0);
        add(0,0,9,1, 4,0);
        // past the pointer wrap
        add(0,1,6,0, 4,1);   add(0,0,6,0, 4,1);   add(0,1,7,0, 4,2);   add(0,0,7,1, 6,1);
        add(0,1,8,1, 7,1);   add(0,0,8,0, 7,1);   add(0,1,10,0, 7,2);  add(0,0,10,0, 7,2);
        add(0,1,11,0, 7,3);  add(0,0,11,1, 8,2);  add(0,0,11,1, 10,1); add(0,0,11,1, 11,0);
        add(0,0,11,0, 11,0);
        // push and pop together on empty: no bypass
        add(0,1,12,1, 11,1); add(0,0,12,1, 12,0); add(0,0,12,0, 12,0);
        // fill to full, then push and pop together at full
        add(0,1,21,0, 12,1); add(0,0,21,0, 12,1); add(0,1,22,0, 12,2); add(0,0,22,0, 12,2);
        add(0,1,23,0, 12,3); add(0,0,23,0, 12,3); add(0,1,24,0, 12,4); add(0,0,24,0, 12,4);
        add(0,1,25,1, 21,4); add(0,0,25,1, 22,3); add(0,0,25,1, 23,2); add(0,0,25,1, 24,1);
        add(0,0,25,1, 25,0);
        // reset mid-operation with ready high across release
        add(0,1,5,0, 25,1);  add(0,0,5,1, 5,0);   add(0,1,30,0, 5,1);  add(0,0,30,0, 5,1);
        add(0,1,31,0, 5,2);  add(1,1,31,1, 0,0);  add(0,1,40,0, 0,1);  add(0,1,40,0, 0,1);
        add(0,0,40,1, 40,0);
        // ready toggling with game_rdy high
        add(0,1,5,1, 40,1);  add(0,0,5,1, 5,0);   add(0,1,5,1, 5,1);   add(0,0,5,1, 5,0);
        add(0,0,5,1, 5,0);

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].rst, vecs[i].rdy, vecs[i].rx, vecs[i].grdy);
            step();
            check($sformatf("vec%0d guess", i), int'(guess), int'(vecs[i].exp_guess));
            check($sformatf("vec%0d count", i), int'(dut.u_fifo.count_q), vecs[i].exp_count);
        end

        // ready held high for many cycles pushes exactly once
        drive(1'b0, 1'b1, 8'd50, 1'b0);
        for (int i = 0; i < 10; i++) begin
            step();
            check($sformatf("held%0d count", i), int'(dut.u_fifo.count_q), 1);
        end
        drive(1'b0, 1'b0, 8'd0, 1'b1);
        step();
        check("held pop guess", int'(guess), 50);
        check("held pop count", int'(dut.u_fifo.count_q), 0);

        // long reset with ready high: one push after release, byte sampled then
        drive(1'b1, 1'b1, 8'd77, 1'b1);
        step();
        step();
        check("rst guess", int'(guess), 0);
        check("rst count", int'(dut.u_fifo.count_q), 0);
        drive(1'b0, 1'b1, 8'd60, 1'b0);
        step();
        Rx_byte = 8'd61;
        step();
        step();
        check("rel count", int'(dut.u_fifo.count_q), 1);
        drive(1'b0, 1'b1, 8'd62, 1'b1);
        step();
        check("rel guess", int'(guess), 60);
        check("rel empty", int'(dut.u_fifo.count_q), 0);
        step();
        check("rel hold", int'(guess), 60);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
